// File: rtl/msx_ddr3_arbiter.sv
// msx_ddr3_arbiter: round-robin sharing of the DDR3 byte port between N req/ack requesters
module msx_ddr3_arbiter #(
  parameter int N    = 4,
  parameter int AW   = 28,
  parameter int HOLD = 15
) (
  input  logic            clk21m,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_wr,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*8-1:0]  req_din,
  output logic [N-1:0]    ack,
  output logic [7:0]      dout,
  output logic [AW-1:0]   ddr3_addr,
  output logic            ddr3_rd,
  output logic            ddr3_wr,
  output logic [7:0]      ddr3_din,
  input  logic [7:0]      ddr3_dout,
  input  logic            ddr3_ready,
  output logic            ddr3_request
);
  localparam int IW = $clog2(N);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;
  state_t         state;
  logic [IW-1:0]  last, grant, nxt, j;
  logic           wr_l;
  logic [3:0]     hold_cnt;
  // next grant: first set req searching upward from last+1 with wrap; lowest distance wins
  always_comb begin
    nxt = last;
    j   = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last) + k) % N);
      nxt = req[j] ? j : nxt;
    end
  end
  // transaction FSM with registered strobes, ack, read data and bus-hold request
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last         <= IW'(N - 1);
      grant        <= '0;
      wr_l         <= 1'b0;
      ack          <= '0;
      dout         <= '0;
      ddr3_addr    <= '0;
      ddr3_din     <= '0;
      ddr3_rd      <= 1'b0;
      ddr3_wr      <= 1'b0;
      ddr3_request <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      ack     <= '0;
      ddr3_rd <= 1'b0;
      ddr3_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant        <= nxt;
            wr_l         <= req_wr[nxt];
            ddr3_addr    <= req_addr[int'(nxt)*AW +: AW];
            ddr3_din     <= req_din[int'(nxt)*8 +: 8];
            ddr3_request <= 1'b1;
            hold_cnt     <= 4'(HOLD);
            state        <= ISSUE;
          end else begin
            if (hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
            if (hold_cnt <= 4'd1) ddr3_request <= 1'b0;
          end
        end
        ISSUE: begin
          if (ddr3_ready) begin
            ddr3_rd <= ~wr_l;
            ddr3_wr <= wr_l;
            state   <= WAIT_LO;
          end
        end
        WAIT_LO: state <= ddr3_ready ? WAIT_LO : WAIT_HI;
        WAIT_HI: begin
          if (ddr3_ready) begin
            if (!wr_l) dout <= ddr3_dout;
            ack[grant] <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          last  <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/msx_ddr3_arbiter.md
# msx_ddr3_arbiter

Shares the single DDR3 byte port between up to N internal requesters: cartridge ROM fetch, keyboard-map load, SRAM save/load and FDC image buffering. It sits between `msx_slots`/`keyboard` and the top-level DDR3 bridge. Each requester runs a simple req/ack byte transaction, and the arbiter serialises the transactions with round-robin fairness. It also holds `ddr3_request` high while any access is pending so that the HPS-side bridge keeps the bus.

## Interface
- `N`, default 4: number of requesters, valid range 2..8.
- `AW`, default 28: DDR3 byte address width.
- `HOLD`, default 15: number of idle cycles `ddr3_request` stays high after the last completion.
- `clk21m` in 1: system clock, 21.477 MHz.
- `reset` in 1: asynchronous, active-high.
- `req` in N: per-requester request level, held until `ack`.
- `req_wr` in N: 1 = write, 0 = read; sampled at grant.
- `req_addr` in N*AW: packed addresses, requester i at [i*AW +: AW]; sampled at grant.
- `req_din` in N*8: packed write data; sampled at grant.
- `ack` out N: one-cycle completion pulse to the granted requester.
- `dout` out 8: read data, valid in the `ack` cycle and held until the next read completes.
- `ddr3_addr` out AW: DDR3 address, registered.
- `ddr3_rd` out 1: one-cycle read strobe.
- `ddr3_wr` out 1: one-cycle write strobe.
- `ddr3_din` out 8: write data, registered.
- `ddr3_dout` in 8: read data from the bridge.
- `ddr3_ready` in 1: bridge idle/complete; goes low the cycle after a strobe and rises when the access completes.
- `ddr3_request` out 1: bus-ownership request to the bridge.

## Operation
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE.
- IDLE: if any `req` is set, grant the first set bit, searching upward from `(last+1) mod N` with wrap-around.
  - Latch the grant index, `req_wr`, address and data into `ddr3_addr`/`ddr3_din`.
  - Set `ddr3_request`, then go to ISSUE.
- ISSUE: if `ddr3_ready`=1, assert `ddr3_rd` or `ddr3_wr` for exactly one cycle and go to WAIT_LO. Otherwise stay in ISSUE with the strobe low.
- WAIT_LO: wait for `ddr3_ready`=0, then go to WAIT_HI. This guards against the stale ready level of the previous access.
- WAIT_HI: on `ddr3_ready`=1, capture `ddr3_dout` into `dout` (reads only) and go to DONE.
- DONE: pulse `ack[grant]` for one cycle, set `last` = grant, and return to IDLE.
  - IDLE may grant a new request in the cycle after DONE.
  - The granted requester must drop `req` on `ack`. If its `req` is still high in IDLE, it competes as a new request.
- `ddr3_request` behaviour:
  - Set on grant.
  - Cleared after `HOLD` consecutive IDLE cycles with no `req`, counted by a 4-bit counter that reloads on every grant.
  - Never cleared while the FSM is outside IDLE.
- A requester that drops `req` after being granted does not abort the transaction. The access completes and `ack` is still pulsed.
- Only the grant index selects `ack`; `ack` has at most one bit set (one-hot).

## Timing
- Reset values:
  - State IDLE, `last` = N-1 (so requester 0 wins first), `ack` = 0, `dout` = 0.
  - `ddr3_rd` = `ddr3_wr` = 0, `ddr3_addr` = 0, `ddr3_din` = 0, `ddr3_request` = 0, hold counter = 0.
- Reset asserted mid-transaction forces all of the above immediately. Any strobe already issued is abandoned and no `ack` is produced.
- Minimum latency, `req` rising edge to `ack`, with the bridge responding in 1 cycle and `ddr3_ready` already high: 5 cycles.
  - IDLE (grant), ISSUE (strobe), WAIT_LO, WAIT_HI (capture), DONE (`ack`).
- Strobes are registered outputs and `ddr3_addr`/`ddr3_din` are stable from the ISSUE cycle until DONE.
- Throughput for back-to-back requests: one access per 5 + bridge latency cycles; no pipelining.
- Simultaneous requests are ordered strictly round-robin, so each requester waits at most N-1 transactions.

## Test plan
1. **Reset and first grant:** release reset, raise `req`=4'b1111, bridge latency 3 cycles.
   - `ack` sequence: 0001, 0010, 0100, 1000.
   - `ddr3_request` stays high throughout and drops 15 idle cycles after the last `ack`.
2. **Read data:** requester 2 reads 0x0123456 while the bridge returns 0xA5.
   - `ddr3_addr` = 0x0123456.
   - `ddr3_rd` high for exactly 1 cycle.
   - `ack` = 4'b0100 with `dout` = 0xA5.
3. **Write path:** requester 1 writes 0x3C to 0x0000100.
   - `ddr3_wr` pulses once with `ddr3_din` = 0x3C.
   - `ddr3_rd` never asserts; `dout` is unchanged.
4. **Ready held low:** hold `ddr3_ready`=0 for 20 cycles after a grant.
   - No strobe during those cycles.
   - The strobe fires in the first cycle with ready = 1; the latched address does not change.
5. **Fairness under contention:** requester 0 re-requests continuously while requester 3 raises `req`.
   - Requester 3 is acked after at most one further requester-0 access.
6. **Reset mid-access:** assert `reset` in WAIT_HI.
   - All outputs return to their reset values asynchronously; no `ack` is pulsed.
   - After release, a pending `req`[0] is granted first.
